// File: rtl/warp_scheduler.sv
// Time-multiplexes LANES kernel lanes over a job: unpack words, launch a batch, collect and repack.
// Define TIMEOUT_EN to compile in the per-batch kernel watchdog (KERNEL_TIMEOUT cycles).
module warp_scheduler #(
  parameter int LANES          = 8,
  parameter int JOB_WORDS      = 128,
  parameter int KERNEL_TIMEOUT = 255
) (
  input  logic                  bus_clk,
  input  logic                  bus_rst_n,
  input  logic                  quiesce,
  input  logic                  xfer_open,
  input  logic                  recv_empty,
  output logic                  recv_rden,
  input  logic [31:0]           recv_data,
  input  logic                  recv_valid,
  input  logic                  send_full,
  output logic                  send_wren,
  output logic [31:0]           send_data,
  output logic [16*LANES-1:0]   lane_in_data,
  output logic [LANES-1:0]      lane_in_valid,
  input  logic [16*LANES-1:0]   lane_out_data,
  input  logic [LANES-1:0]      lane_out_valid,
  output logic                  busy,
  output logic                  job_done,
  output logic                  timeout_err,
  output logic [2:0]            dbg_state
);

  localparam int HALF   = LANES / 2;
  localparam int NBATCH = JOB_WORDS * 2 / LANES;
  localparam int CW     = $clog2(HALF) + 1;
  localparam int BW     = $clog2(NBATCH) + 1;
  localparam logic [CW-1:0] HALF_C    = CW'(HALF);
  localparam logic [CW-1:0] HALF_M1   = CW'(HALF - 1);
  localparam logic [BW-1:0] NBATCH_M1 = BW'(NBATCH - 1);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_LAUNCH, S_WAIT, S_DRAIN} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       req_cnt_q, req_cnt_d;
  logic [CW-1:0]       rcv_cnt_q, rcv_cnt_d;
  logic [CW-1:0]       drain_cnt_q, drain_cnt_d;
  logic [BW-1:0]       batch_cnt_q, batch_cnt_d;
  logic [LANES-1:0]    done_q, done_d, done_nxt;
  logic [16*LANES-1:0] arg_q, arg_d;
  logic [16*LANES-1:0] res_q, res_d;
  logic                abort;

`ifdef TIMEOUT_EN
  localparam int TW = $clog2(KERNEL_TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_M1 = TW'(KERNEL_TIMEOUT - 1);
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          tmo_err_q, tmo_err_d;
`else
  localparam int unused_timeout = KERNEL_TIMEOUT;
`endif

  assign abort = quiesce || !xfer_open;

  // Handshakes: recv_rden pops one word only while !recv_empty, and that word returns
  // with recv_valid exactly one cycle later; send_wren pushes one word only while !send_full.
  always_comb begin
    state_d       = state_q;
    req_cnt_d     = req_cnt_q;
    rcv_cnt_d     = rcv_cnt_q;
    drain_cnt_d   = drain_cnt_q;
    batch_cnt_d   = batch_cnt_q;
    done_d        = done_q;
    arg_d         = arg_q;
    res_d         = res_q;
    done_nxt      = done_q | lane_out_valid;
    recv_rden     = 1'b0;
    send_wren     = 1'b0;
    send_data     = '0;
    lane_in_valid = '0;
    job_done      = 1'b0;
`ifdef TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    tmo_err_d     = tmo_err_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (!abort) begin
          state_d = S_FILL;
`ifdef TIMEOUT_EN
          tmo_err_d = 1'b0;
`endif
        end
      end

      S_FILL: begin
        recv_rden = !recv_empty && (req_cnt_q < HALF_C);
        if (recv_rden) req_cnt_d = req_cnt_q + 1'b1;
        if (recv_valid) begin
          for (int j = 0; j < HALF; j++) begin
            if (rcv_cnt_q == CW'(j)) arg_d[32*j +: 32] = recv_data;
          end
          rcv_cnt_d = rcv_cnt_q + 1'b1;
          if (rcv_cnt_q == HALF_M1) begin
            state_d   = S_LAUNCH;
            req_cnt_d = '0;
            rcv_cnt_d = '0;
          end
        end
      end

      S_LAUNCH: begin
        lane_in_valid = '1;
        done_d        = '0;
        state_d       = S_WAIT;
`ifdef TIMEOUT_EN
        wait_cnt_d    = '0;
`endif
      end

      S_WAIT: begin
        // A repeated strobe simply overwrites the earlier capture.
        for (int i = 0; i < LANES; i++) begin
          if (lane_out_valid[i]) res_d[16*i +: 16] = lane_out_data[16*i +: 16];
        end
        done_d = done_nxt;
        if (&done_nxt) state_d = S_DRAIN;
`ifdef TIMEOUT_EN
        else if (wait_cnt_q == TMO_M1) begin
          for (int i = 0; i < LANES; i++) begin
            if (!done_nxt[i]) res_d[16*i +: 16] = 16'hFFFF;
          end
          done_d    = '1;
          tmo_err_d = 1'b1;
          state_d   = S_DRAIN;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end

      S_DRAIN: begin
        for (int j = 0; j < HALF; j++) begin
          if (drain_cnt_q == CW'(j)) send_data = res_q[32*j +: 32];
        end
        if (!send_full) begin
          send_wren = 1'b1;
          if (drain_cnt_q == HALF_M1) begin
            drain_cnt_d = '0;
            if (batch_cnt_q == NBATCH_M1) begin
              batch_cnt_d = '0;
              job_done    = 1'b1;
              state_d     = S_IDLE;
            end else begin
              batch_cnt_d = batch_cnt_q + 1'b1;
              state_d     = S_FILL;
            end
          end else begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Abort wins over every transition; late recv_valid then lands in IDLE and is dropped.
    if (abort) begin
      state_d     = S_IDLE;
      req_cnt_d   = '0;
      rcv_cnt_d   = '0;
      drain_cnt_d = '0;
      batch_cnt_d = '0;
      done_d      = '0;
    end
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      state_q     <= S_IDLE;
      req_cnt_q   <= '0;
      rcv_cnt_q   <= '0;
      drain_cnt_q <= '0;
      batch_cnt_q <= '0;
      done_q      <= '0;
      arg_q       <= '0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_cnt_q   <= req_cnt_d;
      rcv_cnt_q   <= rcv_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      batch_cnt_q <= batch_cnt_d;
      done_q      <= done_d;
      arg_q       <= arg_d;
      res_q       <= res_d;
    end
  end

`ifdef TIMEOUT_EN
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      wait_cnt_q <= '0;
      tmo_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign lane_in_data = arg_q;
  assign busy         = (state_q != S_IDLE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_warp_scheduler.sv
// Randomized bench for warp_scheduler with FIFO and +1 kernel responders and a word-level scoreboard.
// Build with TIMEOUT_EN defined to also exercise the kernel watchdog.
module tb_warp_scheduler;

  localparam int LANES     = 4;
  localparam int JOB_WORDS = 4;
  localparam int KT        = 10;
  localparam int HALF      = LANES / 2;
  localparam int NB        = JOB_WORDS * 2 / LANES;

  logic                bus_clk;
  logic                bus_rst_n = 1'b0;
  logic                quiesce = 1'b0;
  logic                xfer_open = 1'b0;
  logic                recv_empty = 1'b1;
  logic                recv_rden;
  logic [31:0]         recv_data = '0;
  logic                recv_valid = 1'b0;
  logic                send_full = 1'b0;
  logic                send_wren;
  logic [31:0]         send_data;
  logic [16*LANES-1:0] lane_in_data;
  logic [LANES-1:0]    lane_in_valid;
  logic [16*LANES-1:0] lane_out_data = '0;
  logic [LANES-1:0]    lane_out_valid = '0;
  logic                busy;
  logic                job_done;
  logic                timeout_err;
  logic [2:0]          dbg_state;

  warp_scheduler #(.LANES(LANES), .JOB_WORDS(JOB_WORDS), .KERNEL_TIMEOUT(KT)) dut (
    .bus_clk(bus_clk), .bus_rst_n(bus_rst_n), .quiesce(quiesce), .xfer_open(xfer_open),
    .recv_empty(recv_empty), .recv_rden(recv_rden), .recv_data(recv_data), .recv_valid(recv_valid),
    .send_full(send_full), .send_wren(send_wren), .send_data(send_data),
    .lane_in_data(lane_in_data), .lane_in_valid(lane_in_valid),
    .lane_out_data(lane_out_data), .lane_out_valid(lane_out_valid),
    .busy(busy), .job_done(job_done), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    bus_clk = 1'b0;
    forever #5 bus_clk = ~bus_clk;
  end

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] in_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] rcv_hist[$];

  bit          rd_pend = 1'b0;
  logic [31:0] rd_word = '0;
  int          cd[LANES];
  logic [15:0] kv[LANES];
  int  empty_mode = 0;
  bit  tog = 1'b0;
  bit  full_rand = 1'b0;
  bit  full_arm = 1'b0;
  int  full_cnt = 0;
  int  lat_lo = 1, lat_hi = 3;
  int  dead_lane = -1;
  int  launches = 0, jobs = 0, out_cnt = 0, cyc = 0;
  int  last_launch = 0, lat_obs = 0;
  bit  first_wr = 1'b0, prev_launch = 1'b0, busy_chk = 1'b0;
  logic tmo_at_done = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Result word for input word w at job position k: each half plus one, or all ones for a dead lane.
  function automatic logic [31:0] exp_word(input logic [31:0] w, input int k);
    logic [15:0] lo, hi;
    lo = w[15:0] + 16'd1;
    hi = w[31:16] + 16'd1;
    if (dead_lane == 2 * (k % HALF))     lo = 16'hFFFF;
    if (dead_lane == 2 * (k % HALF) + 1) hi = 16'hFFFF;
    return {hi, lo};
  endfunction

  // ---------------- driver: FIFOs and kernel lanes, monitor ----------------
  initial begin : cycle_proc
    logic [16*LANES-1:0] exp_lanes;
    for (int i = 0; i < LANES; i++) begin cd[i] = 0; kv[i] = '0; end
    forever begin
      @(negedge bus_clk);
      cyc++;
      recv_valid = rd_pend;
      recv_data  = rd_pend ? rd_word : $urandom();
      if (rd_pend) rcv_hist.push_back(rd_word);
      rd_pend = 1'b0;
      for (int i = 0; i < LANES; i++) begin
        lane_out_valid[i] = (cd[i] == 1) && (i != dead_lane);
        lane_out_data[16*i +: 16] = lane_out_valid[i] ? kv[i] : 16'($urandom());
        if (cd[i] > 0) cd[i]--;
      end
      tog = !tog;
      recv_empty = (in_q.size() == 0) || (empty_mode == 1 && tog) ||
                   (empty_mode == 2 && $urandom_range(0, 2) == 0);
      if (full_cnt > 0) begin
        send_full = 1'b1;
        full_cnt--;
      end else begin
        send_full = full_rand && ($urandom_range(0, 3) == 0);
      end

      #1;
      check("rden_while_empty", recv_rden && recv_empty, 1'b0);
      check("wren_while_full", send_wren && send_full, 1'b0);
      if (recv_rden && in_q.size() > 0) begin
        rd_word = in_q.pop_front();
        rd_pend = 1'b1;
      end

      if (send_wren) begin
        out_cnt++;
        if (exp_q.size() == 0) check("unexpected_write", 1'b1, 1'b0);
        else check("send_data", send_data, exp_q.pop_front());
        if (first_wr) begin
          lat_obs  = cyc - last_launch;
          first_wr = 1'b0;
        end
        if (full_arm && (out_cnt % HALF) == 1) begin
          full_cnt = 5;
          full_arm = 1'b0;
        end
      end

      if (prev_launch) check("launch_width", lane_in_valid, '0);
      prev_launch = |lane_in_valid;
      if (|lane_in_valid) begin
        launches++;
        check("launch_mask", lane_in_valid, {LANES{1'b1}});
        check("words_before_launch", rcv_hist.size(), HALF);
        exp_lanes = '0;
        for (int k = 0; k < HALF; k++)
          if (rcv_hist.size() > 0) exp_lanes[32*k +: 32] = rcv_hist.pop_front();
        check("lane_in_data", lane_in_data, exp_lanes);
        for (int i = 0; i < LANES; i++) begin
          cd[i] = $urandom_range(lat_lo, lat_hi);
          kv[i] = lane_in_data[16*i +: 16] + 16'd1;
        end
        last_launch = cyc;
        first_wr    = 1'b1;
      end

      if (busy_chk) check("idle_after_job", busy, 1'b0);
      busy_chk = job_done;
      if (job_done) begin
        jobs++;
        tmo_at_done = timeout_err;
        check("done_at_job_end", exp_q.size(), 0);
      end
    end
  end

  task automatic push_job(input bit fixed);
    logic [31:0] w;
    logic [31:0] fw[4];
    fw = '{32'h0002_0001, 32'h0004_0003, 32'h0006_0005, 32'h0008_0007};
    for (int k = 0; k < JOB_WORDS; k++) begin
      w = fixed ? fw[k % 4] : $urandom();
      exp_q.push_back(exp_word(w, k));
      in_q.push_back(w);
    end
  endtask

  task automatic run_job(input string tag, input bit fixed);
    int j0, l0, t;
    j0 = jobs;
    l0 = launches;
    push_job(fixed);
    t = 0;
    while (jobs == j0 && t < 3000) begin
      @(negedge bus_clk);
      t++;
    end
    check({tag, "_finished"}, jobs != j0, 1'b1);
    repeat (4) @(negedge bus_clk);
    check({tag, "_done_pulses"}, jobs - j0, 1);
    check({tag, "_launches"}, launches - l0, NB);
    check({tag, "_all_words_out"}, exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main_proc
    int l0, o0, t;
    bit found;
    repeat (3) @(negedge bus_clk);
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_rden", recv_rden, 1'b0);
    check("rst_wren", send_wren, 1'b0);
    check("rst_launch", lane_in_valid, '0);
    check("rst_job_done", job_done, 1'b0);
    check("rst_timeout", timeout_err, 1'b0);
    check("rst_send_data", send_data, '0);
    check("rst_lane_data", lane_in_data, '0);
    check("rst_state", dbg_state, 3'd0);
    bus_rst_n = 1'b1;
    @(negedge bus_clk);
    xfer_open = 1'b1;

    run_job("basic", 1'b1);
    full_arm = 1'b1;
    run_job("full_stall", 1'b1);
    empty_mode = 1;
    run_job("empty_toggle", 1'b1);
    empty_mode = 0;

    // Close the transfer while batch 1 waits on slow kernels.
    lat_lo = 8; lat_hi = 8;
    l0 = launches;
    push_job(1'b0);
    t = 0;
    while (launches < l0 + 2 && t < 500) begin
      @(negedge bus_clk);
      t++;
    end
    check("abort_reached_batch1", launches - l0, 2);
    repeat (2) @(negedge bus_clk);
    o0 = out_cnt;
    xfer_open = 1'b0;
    @(negedge bus_clk);
    #2;
    check("abort_idle_next", busy, 1'b0);
    repeat (12) @(negedge bus_clk);
    check("abort_no_writes", out_cnt - o0, 0);
    check("abort_stays_idle", busy, 1'b0);
    check("abort_dropped_batch", exp_q.size(), HALF);
    exp_q.delete();
    rcv_hist.delete();
    rd_pend = 1'b0;
    lat_lo = 1; lat_hi = 4;
    xfer_open = 1'b1;
    run_job("restart", 1'b0);

    full_rand = 1'b1;
    empty_mode = 2;
    lat_lo = 1; lat_hi = 5;
    for (int n = 0; n < 4; n++) run_job("random", 1'b0);
    full_rand = 1'b0;
    empty_mode = 0;

`ifdef TIMEOUT_EN
    dead_lane = 3;
    run_job("timeout", 1'b0);
    check("timeout_wait_len", lat_obs, KT + 1);
    check("timeout_flag_at_done", tmo_at_done, 1'b1);
    check("timeout_clear_on_refill", timeout_err, 1'b0);
    dead_lane = -1;
`else
    check("timeout_tied_low", timeout_err, 1'b0);
`endif

    // Asynchronous reset between edges while the final word of a job is being written.
    lat_lo = 2; lat_hi = 2;
    push_job(1'b0);
    t = 0;
    found = 1'b0;
    while (!found && t < 500) begin
      @(negedge bus_clk);
      #2;
      found = send_wren && job_done;
      t++;
    end
    check("arst_reached_last_word", found, 1'b1);
    bus_rst_n = 1'b0;
    #1;
    check("arst_wren", send_wren, 1'b0);
    check("arst_launch", lane_in_valid, '0);
    check("arst_busy", busy, 1'b0);
    check("arst_job_done", job_done, 1'b0);
    in_q.delete();
    exp_q.delete();
    rcv_hist.delete();
    rd_pend = 1'b0;
    for (int i = 0; i < LANES; i++) cd[i] = 0;
    repeat (2) @(negedge bus_clk);
    bus_rst_n = 1'b1;
    lat_lo = 1; lat_hi = 4;
    run_job("after_reset", 1'b1);

    repeat (3) @(negedge bus_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #400000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "time limit");
  end

endmodule
